// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller and its helpers.
package pwm_pkg;

    // Default compare width; must match the pwm_generator instances on the bus.
    localparam int unsigned COMPARE_SIZE = 8;

    // Write handshake shape required by the generator's write-once latch.
    localparam int unsigned WR_HOLD_CYCLES = 2;
    localparam int unsigned WR_GAP_CYCLES  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StWrAssert,
        StWrRelease
    } ramp_state_t;

endpackage

// File: rtl/pwm_gamma_lut.sv
// pwm_gamma_lut: combinational gamma table mapping linear ramp steps to perceptual
// brightness (quadratic curve). Endpoints are exact: 0 -> 0 and max -> max.
// Used by pwm_ramp_ctrl only when PWM_RAMP_GAMMA_EN is defined.
module pwm_gamma_lut #(
    parameter int unsigned COMPARE_SIZE = pwm_pkg::COMPARE_SIZE
) (
    input  logic [COMPARE_SIZE-1:0] lin_val,
    output logic [COMPARE_SIZE-1:0] gamma_val
);

    logic [2*COMPARE_SIZE-1:0] lin_ext;
    logic [2*COMPARE_SIZE-1:0] sq;
    logic [2*COMPARE_SIZE-1:0] max_ext;
    logic [2*COMPARE_SIZE-1:0] quot;

    // out = lin^2 / max; constant divisor folds into a fixed table in synthesis.
    always_comb begin
        lin_ext   = {{COMPARE_SIZE{1'b0}}, lin_val};
        max_ext   = {{COMPARE_SIZE{1'b0}}, {COMPARE_SIZE{1'b1}}};
        sq        = lin_ext * lin_ext;
        quot      = sq / max_ext;
        gamma_val = quot[COMPARE_SIZE-1:0];
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: steps a bank of pwm_generator compare values toward commanded targets
// over one shared compare bus with one-hot write strobes and round-robin arbitration.
// Each write is a 2-cycle strobe followed by a 1-cycle gap.
// Build option: define PWM_RAMP_GAMMA_EN to drive the bus through pwm_gamma_lut.
module pwm_ramp_ctrl #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned COMPARE_SIZE = pwm_pkg::COMPARE_SIZE,
    parameter int unsigned DIV_W        = 16
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
    input  logic [COMPARE_SIZE-1:0]   cmd_target,
    input  logic [DIV_W-1:0]          cmd_step_div,
    output logic [COMPARE_SIZE-1:0]   pwm_compare,
    output logic [NUM_CH-1:0]         pwm_wr,
    output logic                      busy,
    output logic [NUM_CH-1:0]         done
);

    import pwm_pkg::*;

    localparam int unsigned ChW = $clog2(NUM_CH);

    typedef logic [COMPARE_SIZE-1:0] val_t;
    typedef logic [DIV_W-1:0]        div_t;

    ramp_state_t       state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ChW-1:0]    gnt_q, gnt_d;
    val_t              cur_q [NUM_CH];
    val_t              cur_d [NUM_CH];
    val_t              tgt_q [NUM_CH];
    val_t              tgt_d [NUM_CH];
    div_t              div_q [NUM_CH];
    div_t              div_d [NUM_CH];
    div_t              cnt_q [NUM_CH];
    div_t              cnt_d [NUM_CH];
    val_t              cmp_q, cmp_d;
    logic [NUM_CH-1:0] wr_q, wr_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic              busy_q, busy_d;

    logic [NUM_CH-1:0] pend;
    logic              grant_vld;
    logic [ChW-1:0]    pick;
    val_t              step_val;
    val_t              bus_val;
    logic              cmd_hit;
    logic              cmd_inflight;
    int unsigned       idx;

    // Pending channels and round-robin pick, searching from the channel after the last grant.
    always_comb begin
        pend      = '0;
        grant_vld = 1'b0;
        pick      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pend[i] = (cnt_q[i] == '0) && (cur_q[i] != tgt_q[i]);
        end
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(gnt_q) + k) % NUM_CH;
            if (!grant_vld && pend[idx]) begin
                grant_vld = 1'b1;
                pick      = ChW'(idx);
            end
        end
    end

    // New value for the picked channel: jump when div is 0, else one LSB toward target.
    always_comb begin
        if (div_q[pick] == '0) begin
            step_val = tgt_q[pick];
        end else if (cur_q[pick] < tgt_q[pick]) begin
            step_val = cur_q[pick] + 1'b1;
        end else begin
            step_val = cur_q[pick] - 1'b1;
        end
    end

`ifdef PWM_RAMP_GAMMA_EN
    pwm_gamma_lut #(
        .COMPARE_SIZE (COMPARE_SIZE)
    ) u_gamma_lut (
        .lin_val   (step_val),
        .gamma_val (bus_val)
    );
`else
    assign bus_val = step_val;
`endif

    // Command intake, write FSM, per-channel value/counter updates and busy tracking.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        gnt_d   = gnt_q;
        cmp_d   = cmp_q;
        wr_d    = '0;
        done_d  = '0;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        div_d   = div_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : '0;
        end

        cmd_hit      = cmd_valid && (32'(cmd_ch) < NUM_CH);
        // The grant cycle already counts as in flight: cur is being overwritten this edge.
        cmd_inflight = ((state_q != StIdle) && (gnt_q == cmd_ch)) ||
                       ((state_q == StIdle) && grant_vld && (pick == cmd_ch));

        if (cmd_hit) begin
            tgt_d[cmd_ch] = cmd_target;
            div_d[cmd_ch] = cmd_step_div;
            if ((cmd_target == cur_q[cmd_ch]) && !cmd_inflight) begin
                done_d[cmd_ch] = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    state_d     = StWrAssert;
                    phase_d     = '0;
                    gnt_d       = pick;
                    cur_d[pick] = step_val;
                    cmp_d       = bus_val;
                    // The grant cycle is the first of the interval, so reload div-1 to keep
                    // grant-to-grant spacing equal to div.
                    cnt_d[pick] = (div_q[pick] == '0) ? '0 : div_q[pick] - 1'b1;
                end
            end
            StWrAssert: begin
                // Strobe is registered, so the bus sees it one cycle after this state.
                wr_d[gnt_q] = 1'b1;
                if (phase_q == 2'(WR_HOLD_CYCLES - 1)) begin
                    state_d = StWrRelease;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StWrRelease: begin
                if (phase_q == 2'(WR_GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                    phase_d = '0;
                    if (cur_q[gnt_q] == tgt_d[gnt_q]) begin
                        done_d[gnt_q] = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Command reload wins over the grant reload.
        if (cmd_hit) begin
            cnt_d[cmd_ch] = cmd_step_div;
        end

        busy_d = (state_d != StIdle);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cur_d[i] != tgt_d[i]) begin
                busy_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; search starts at ch0 after reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            gnt_q   <= ChW'(NUM_CH - 1);
            cmp_q   <= '0;
            wr_q    <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cur_q[i] <= '0;
                tgt_q[i] <= '0;
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            gnt_q   <= gnt_d;
            cmp_q   <= cmp_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cur_q[i] <= cur_d[i];
                tgt_q[i] <= tgt_d[i];
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cmd_ready   = 1'b1;
    assign pwm_compare = cmp_q;
    assign pwm_wr      = wr_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: expected writes and done pulses are queued with their
// predicted cycle when a command is driven, then popped as the DUT produces them.
module tb_pwm_ramp_ctrl;

    logic        sys_clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [7:0]  cmd_target;
    logic [15:0] cmd_step_div;
    logic [7:0]  pwm_compare;
    logic [3:0]  pwm_wr;
    logic        busy;
    logic [3:0]  done;

    pwm_ramp_ctrl #(
        .NUM_CH       (4),
        .COMPARE_SIZE (8),
        .DIV_W        (16)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ch       (cmd_ch),
        .cmd_target   (cmd_target),
        .cmd_step_div (cmd_step_div),
        .pwm_compare  (pwm_compare),
        .pwm_wr       (pwm_wr),
        .busy         (busy),
        .done         (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int ch;
        int val;
        int cyc;
    } ev_t;

    ev_t        wq[$];
    ev_t        dq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         wr_age = 0;
    logic [3:0] wr_seen;
    logic [7:0] cmp_seen;
    int         n;
    int         m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input int ch, input int val, input int c);
        ev_t e;
        e.ch  = ch;
        e.val = val;
        e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic push_done(input int ch, input int c);
        ev_t e;
        e.ch  = ch;
        e.val = 0;
        e.cyc = c;
        dq.push_back(e);
    endtask

    // One clock; sample 1 time unit after the edge and score writes and done pulses.
    task automatic step();
        ev_t e;
        @(posedge sys_clk);
        cyc++;
        #1;
        if (wr_age == 1) begin
            check("wr_hold", 32'(pwm_wr), 32'(wr_seen));
            check("cmp_hold_a", 32'(pwm_compare), 32'(cmp_seen));
            wr_age = 2;
        end else if (wr_age == 2) begin
            check("wr_gap", 32'(pwm_wr), 0);
            check("cmp_hold_b", 32'(pwm_compare), 32'(cmp_seen));
            wr_age = 0;
        end else if (pwm_wr !== 4'b0000) begin
            checks++;
            assert (wq.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%0h expected=none", pwm_wr);
            end
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("wr_strobe", 32'(pwm_wr), 32'(1 << e.ch));
                check("wr_value", 32'(pwm_compare), e.val);
                check("wr_cycle", cyc, e.cyc);
            end
            wr_age   = 1;
            wr_seen  = pwm_wr;
            cmp_seen = pwm_compare;
        end
        for (int i = 0; i < 4; i++) begin
            if (done[i] !== 1'b0) begin
                checks++;
                assert (dq.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_done observed=ch%0d expected=none", i);
                end
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    check("done_ch", i, e.ch);
                    check("done_cycle", cyc, e.cyc);
                    check("busy_at_done", 32'(busy),
                          (wq.size() != 0 || dq.size() != 0) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic send_cmd(input int ch, input int tgt, input int dv);
        cmd_valid    = 1'b1;
        cmd_ch       = 2'(ch);
        cmd_target   = 8'(tgt);
        cmd_step_div = 16'(dv);
        step();
        cmd_valid    = 1'b0;
    endtask

    task automatic run_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic drain(input string tag);
        int budget = 2000;
        while ((wq.size() != 0 || dq.size() != 0) && budget > 0) begin
            step();
            budget--;
        end
        check({tag, "_pending"}, wq.size() + dq.size(), 0);
        repeat (6) step();
        check({tag, "_busy_idle"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        wr_age = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_ch       = '0;
        cmd_target   = '0;
        cmd_step_div = '0;
        repeat (3) step();
        check("rst_wr", 32'(pwm_wr), 0);
        check("rst_cmp", 32'(pwm_compare), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("cmd_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        step();

        // Reset during the write strobe kills the write and leaves nothing pending.
        n = cyc + 1;
        push_wr(0, 3, n + 2);
        send_cmd(0, 3, 0);
        run_until(n + 2);
        rst_n  = 1'b0;
        wr_age = 0;
        step();
        check("midrst_wr", 32'(pwm_wr), 0);
        check("midrst_cmp", 32'(pwm_compare), 0);
        check("midrst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (10) step();
        check("midrst_quiet", wq.size() + dq.size(), 0);

        // Jump: div 0 writes the target directly.
        n = cyc + 1;
        push_wr(0, 200, n + 2);
        push_done(0, n + 4);
        send_cmd(0, 200, 0);
        check("jump_busy", 32'(busy), 1);
        drain("jump");

        // Ramp up ch1 0 -> 4 at div 10.
        n = cyc + 1;
        for (int k = 1; k <= 4; k++) push_wr(1, k, n + 2 + 10 * k);
        push_done(1, n + 44);
        send_cmd(1, 4, 10);
        drain("ramp_up");

        // Ramp down ch2 5 -> 2 at div 4.
        n = cyc + 1;
        push_wr(2, 5, n + 2);
        push_done(2, n + 4);
        send_cmd(2, 5, 0);
        drain("preset5");
        m = cyc + 1;
        push_wr(2, 4, m + 6);
        push_wr(2, 3, m + 10);
        push_wr(2, 2, m + 14);
        push_done(2, m + 16);
        send_cmd(2, 2, 4);
        drain("ramp_down");

        // Fairness: four back-to-back jump commands are served in order, 4 cycles apart.
        do_reset();
        n = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            push_wr(i, 10 * (i + 1), n + 2 + 4 * i);
            push_done(i, n + 4 + 4 * i);
        end
        for (int i = 0; i < 4; i++) send_cmd(i, 10 * (i + 1), 0);
        drain("fair");

        // Target equal to current value: no write, done on the next cycle.
        n = cyc + 1;
        push_done(0, n);
        send_cmd(0, 10, 0);
        drain("same_tgt");

        // Retarget ch3 while its write of 3 is in flight.
        do_reset();
        n = cyc + 1;
        push_wr(3, 1, n + 10);
        push_wr(3, 2, n + 18);
        push_wr(3, 3, n + 26);
        send_cmd(3, 100, 8);
        run_until(n + 25);
        push_wr(3, 2, n + 36);
        push_done(3, n + 38);
        send_cmd(3, 2, 8);
        drain("retarget");

        // Full-range ramps: no wrap at either end, spacing limited to 4 cycles.
        n = cyc + 1;
        for (int k = 1; k <= 255; k++) push_wr(1, k, n + 3 + 4 * (k - 1));
        push_done(1, n + 3 + 4 * 254 + 2);
        send_cmd(1, 255, 1);
        drain("full_up");
        m = cyc + 1;
        for (int j = 0; j <= 254; j++) push_wr(1, 254 - j, m + 3 + 4 * j);
        push_done(1, m + 3 + 4 * 254 + 2);
        send_cmd(1, 0, 1);
        drain("full_down");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Shared-bus ramp controller for a bank of `pwm_generator` channels. It accepts per-channel target duty and step-rate commands, then steps each channel's compare value toward its target one LSB at a time. All channels share one compare bus with one-hot write strobes, and a round-robin arbiter decides which channel is written next. Every write uses the wr-high/wr-low pattern that the generator's write-once latch requires.

## Interface
- `NUM_CH`, 4, number of PWM channels served (2..16)
- `COMPARE_SIZE`, 8, compare width; must match the generators
- `DIV_W`, 16, width of the per-channel step divider
- `sys_clk` in 1, system clock
- `rst_n` in 1, reset; synchronous, active-low
- `cmd_valid` in 1, command present
- `cmd_ready` out 1, command accepted when high with `cmd_valid`; tied high
- `cmd_ch` in $clog2(NUM_CH), target channel; values ≥ `NUM_CH` are accepted and dropped
- `cmd_target` in COMPARE_SIZE, final compare value
- `cmd_step_div` in DIV_W, sys_clk cycles between steps; 0 = jump directly to target
- `pwm_compare` out COMPARE_SIZE, shared compare bus to all generators
- `pwm_wr` out NUM_CH, one-hot write strobes, one per generator
- `busy` out 1, high while any channel has current ≠ target or a write is in flight
- `done` out NUM_CH, one-cycle pulse per channel when it reaches its target

## Operation
- **Per-channel state:** `cur`, `tgt`, `div` (reload value), `cnt` (down-counter). All reset to 0.
- **Command accept:** on `cmd_valid`, load `tgt` ← `cmd_target`, `div` ← `cmd_step_div`, `cnt` ← `cmd_step_div`.
- **Counter:** `cnt` decrements each cycle while nonzero and saturates at 0.
- **Pending:** a channel is pending when `cnt == 0` and `cur != tgt`.
- **FSM states:** IDLE, WR_ASSERT (2 cycles), WR_RELEASE (1 cycle).
- **IDLE:** if any channel is pending, grant one by round-robin, starting at the channel after the last grant (after reset, the search starts at ch0). In the grant cycle:
  - if `div == 0`, `cur` ← `tgt`; otherwise `cur` ← `cur ± 1` toward `tgt`;
  - `cnt` ← `div`;
  - `pwm_compare` ← new `cur`;
  - go to WR_ASSERT.
- **WR_ASSERT:** `pwm_wr[g]` = 1 for exactly 2 cycles; `pwm_compare` stays stable.
- **WR_RELEASE:** `pwm_wr` = 0 for 1 cycle; `pwm_compare` is held. If the new `cur == tgt`, `done[g]` pulses in this cycle. Then return to IDLE.
- **Command during a write to the same channel:** the in-flight write completes with its already-latched value. The new `tgt`/`div` apply from the next grant. The counter reload from the command wins over the grant reload in the same cycle.
- **Command with `cmd_target == cur` and no write in flight for that channel:** no write is issued; `done[ch]` pulses on the next cycle.
- **Arithmetic:** `cur` never overshoots `tgt`. There is no wrap-around: ramps from 0→max and max→0 run monotonically. A step is a single ±1.
- `pwm_compare` holds its last value in IDLE and after reset is 0.

## Timing
- Reset values: `pwm_wr` = 0, `pwm_compare` = 0, `done` = 0, `busy` = 0, FSM in IDLE. Reset mid-write drops `pwm_wr` at the next edge.
- A command accepted at edge N with `div == 0` is granted at N+1. `pwm_wr` is high over N+2..N+3 and low at N+4.
- Grant-to-grant spacing for one channel = max(`div`, 4) cycles.
- With k pending channels, each channel is serviced at least every 4·k cycles.
- `busy` is registered and drops the cycle after the last WR_RELEASE.

## Configuration
- `PWM_RAMP_GAMMA_EN` defined:
  - `pwm_compare` = gamma-corrected `cur`, from a LUT mapping linear ramp steps to perceptual brightness;
  - the LUT maps 0 → 0 and max → max;
  - the LUT output is registered at grant, so timing is unchanged.
- `PWM_RAMP_GAMMA_EN` undefined: `pwm_compare` = `cur`, linear.

## Structure
- Shared package `pwm_pkg` holds:
  - `COMPARE_SIZE` default;
  - FSM state enum `ramp_state_t` (IDLE, WR_ASSERT, WR_RELEASE);
  - `WR_HOLD_CYCLES` = 2;
  - `WR_GAP_CYCLES` = 1.
- Sub-module `pwm_gamma_lut`: combinational COMPARE_SIZE → COMPARE_SIZE table, instantiated only under `PWM_RAMP_GAMMA_EN`.
- Round-robin arbitration stays inline.

## Test plan
- **Reset mid-write:** command ch0 target 3 div 0, then assert `rst_n`=0 during WR_ASSERT → `pwm_wr` = 0 next edge, `pwm_compare` = 0, `busy` = 0, and no write follows release.
- **Jump:** ch0 target 200 div 0 → exactly one write: `pwm_compare` = 200, `pwm_wr[0]` high for 2 cycles then 1 cycle low, `done[0]` pulses in the release cycle.
- **Ramp up:** ch1 target 4 div 10 from 0 → writes 1, 2, 3, 4 with grants 10 cycles apart, a single `done[1]`, then `busy` falls.
- **Ramp down:** ch2 at 5, command target 2 div 4 → writes 4, 3, 2 spaced 4 cycles; value never below 2.
- **Fairness:** all 4 channels commanded in consecutive cycles, div 0, distinct targets → grants in order 0, 1, 2, 3, one write each, 4 cycles apart.
- **Retarget:** ch3 ramping 0→100 div 8, retarget to 2 while writing 3 → the in-flight 3 completes, next write 2, `done[3]` pulses once.
